// File: rtl/coef_load_ctrl.sv
// Coefficient load sequencer: unpacks a byte stream (3 bytes -> 2 x 12-bit)
// and shifts N_COEF coefficients into the FIR coefficient bank.
module coef_load_ctrl #(
    parameter int N_COEF = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_req,
    input  logic        abort,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic [11:0] coef_out,
    output logic        enable_8a12,
    output logic        busy,
    output logic        done,
    output logic        coef_ready
);

    localparam int CW = (N_COEF > 1) ? $clog2(N_COEF) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(N_COEF - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_B0   = 2'd1;
    localparam logic [1:0] S_B1   = 2'd2;
    localparam logic [1:0] S_B2   = 2'd3;

    logic [1:0]    state_reg, state_next;
    logic [7:0]    hold_reg, hold_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [11:0]   coef_reg, coef_next;
    logic          en_reg, en_next;
    logic          done_reg, done_next;
    logic          cready_reg, cready_next;
    logic          hs;

    assign busy        = (state_reg != S_IDLE);
    assign byte_ready  = busy;
    assign hs          = byte_valid && byte_ready;
    assign coef_out    = coef_reg;
    assign enable_8a12 = en_reg;
    assign done        = done_reg;
    assign coef_ready  = cready_reg;

    always_comb begin
        state_next  = state_reg;
        hold_next   = hold_reg;
        cnt_next    = cnt_reg;
        coef_next   = coef_reg;
        en_next     = 1'b0;
        done_next   = 1'b0;
        cready_next = cready_reg;

        if (state_reg == S_IDLE) begin
            if (load_req && !abort) begin
                state_next  = S_B0;
                cnt_next    = '0;
                cready_next = 1'b0;
            end
        end else if (abort) begin
            // A byte handshaking alongside abort is swallowed without effect.
            state_next = S_IDLE;
        end else if (hs) begin
            if (state_reg == S_B0) begin
                hold_next  = byte_in;
                state_next = S_B1;
            end else if (state_reg == S_B1) begin
                coef_next  = {hold_reg, byte_in[7:4]};
                en_next    = 1'b1;
                cnt_next   = cnt_reg + CW'(1);
                hold_next  = {4'h0, byte_in[3:0]};
                state_next = S_B2;
            end else begin
                coef_next = {hold_reg[3:0], byte_in};
                en_next   = 1'b1;
                if (cnt_reg == LAST_IDX) begin
                    // Counter is left at the last index so it never wraps.
                    state_next  = S_IDLE;
                    done_next   = 1'b1;
                    cready_next = 1'b1;
                end else begin
                    cnt_next   = cnt_reg + CW'(1);
                    state_next = S_B0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= S_IDLE;
            hold_reg   <= '0;
            cnt_reg    <= '0;
            coef_reg   <= '0;
            en_reg     <= 1'b0;
            done_reg   <= 1'b0;
            cready_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            hold_reg   <= hold_next;
            cnt_reg    <= cnt_next;
            coef_reg   <= coef_next;
            en_reg     <= en_next;
            done_reg   <= done_next;
            cready_reg <= cready_next;
        end
    end

endmodule

// File: tb/tb_coef_load_ctrl.sv
// Bench for coef_load_ctrl: driver pushes expected coefficients into a queue,
// an independent monitor pops and compares on every enable_8a12 strobe.
module tb_coef_load_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load_req = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic [11:0] coef_out;
    logic        enable_8a12;
    logic        busy;
    logic        done;
    logic        coef_ready;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int strobes = 0;
    int dones = 0;
    int done_edge = 0;
    logic [11:0] exp_q[$];
    logic [11:0] mon_exp;
    logic [7:0]  pat [3] = '{8'h12, 8'h34, 8'h56};

    coef_load_ctrl #(.N_COEF(16)) dut (
        .clk(clk), .rst(rst), .load_req(load_req), .abort(abort),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .coef_out(coef_out), .enable_8a12(enable_8a12), .busy(busy),
        .done(done), .coef_ready(coef_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every strobe must match the oldest expected coefficient.
    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
        end else begin
            if (enable_8a12) begin
                strobes++;
                check("strobe_has_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    mon_exp = exp_q.pop_front();
                    check("coef_out", int'(coef_out), int'(mon_exp));
                    $display("strobe %0d: coef_out=0x%03h expected=0x%03h", strobes, coef_out, mon_exp);
                end
            end
            if (done) begin
                dones++;
                done_edge = cyc + 1;
                check("strobe_with_done", int'(enable_8a12), 1);
                check("busy_at_done", int'(busy), 0);
            end
        end
    end

    task automatic check_all_zero(input string name);
        check(name, int'({byte_ready, coef_out, enable_8a12, busy, done, coef_ready}), 0);
    endtask

    // Runs one load; stall!=0 randomises byte_valid, abort_at>=0 aborts after that
    // many accepted bytes, req_at>=0 re-pulses load_req while busy.
    task automatic drive_load(input int stall, input int abort_at, input int req_at);
        int acc = 0;
        int guard = 0;
        int s0 = strobes;
        int d0 = dones;
        int req_edge;
        logic [7:0] b;
        logic [7:0] b0 = 8'h00;
        logic [7:0] b1 = 8'h00;

        load_req = 1'b1;
        abort = 1'b0;
        req_edge = cyc + 1;
        @(negedge clk);
        load_req = 1'b0;
        check("busy_after_req", int'(busy), 1);
        check("byte_ready_after_req", int'(byte_ready), 1);
        check("coef_ready_cleared", int'(coef_ready), 0);

        while (acc < 24 && guard < 400) begin
            b = pat[acc % 3];
            byte_in = b;
            byte_valid = (stall != 0) ? 1'($urandom_range(1, 0)) : 1'b1;
            load_req = (req_at >= 0 && acc == req_at);
            abort = (abort_at >= 0 && acc == abort_at);
            if (byte_valid && byte_ready && !abort) begin
                case (acc % 3)
                    0: b0 = b;
                    1: begin exp_q.push_back({b0, b[7:4]}); b1 = b; end
                    default: exp_q.push_back({b1[3:0], b});
                endcase
                acc++;
            end
            @(negedge clk);
            guard++;
            if (abort) break;
        end
        byte_valid = 1'b0;
        load_req = 1'b0;

        if (abort_at >= 0) begin
            abort = 1'b0;
            check("busy_after_abort", int'(busy), 0);
            repeat (3) @(negedge clk);
            check("abort_strobes", strobes - s0, (abort_at / 3) * 2 + ((abort_at % 3 == 2) ? 1 : 0));
            check("abort_no_done", dones - d0, 0);
            check("abort_coef_ready", int'(coef_ready), 0);
            check("abort_queue_empty", exp_q.size(), 0);
            $display("abort load: strobes=%0d dones=%0d coef_ready=%0b", strobes - s0, dones - d0, coef_ready);
        end else begin
            check("load_in_budget", int'(guard < 400), 1);
            repeat (3) @(negedge clk);
            check("load_strobes", strobes - s0, 16);
            check("load_dones", dones - d0, 1);
            check("load_coef_ready", int'(coef_ready), 1);
            check("load_busy_idle", int'(busy), 0);
            check("load_queue_empty", exp_q.size(), 0);
            if (stall == 0 && req_at < 0)
                check("done_latency", done_edge - req_edge, 25);
            $display("full load (stall=%0d req_at=%0d): strobes=%0d dones=%0d done_latency=%0d",
                     stall, req_at, strobes - s0, dones - d0, done_edge - req_edge);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Power-on reset with random inputs
        for (int i = 0; i < 3; i++) begin
            load_req = 1'($urandom_range(1, 0));
            abort = 1'($urandom_range(1, 0));
            byte_valid = 1'($urandom_range(1, 0));
            byte_in = 8'($urandom_range(255, 0));
            @(negedge clk);
            check_all_zero("reset_outputs");
        end
        load_req = 1'b0; abort = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("after_release");

        // load_req with abort in IDLE: abort wins
        load_req = 1'b1; abort = 1'b1;
        @(negedge clk);
        load_req = 1'b0; abort = 1'b0;
        check("req_abort_idle_busy", int'(busy), 0);
        $display("req+abort in idle: busy=%0b", busy);

        drive_load(0, -1, -1);   // continuous
        drive_load(1, -1, -1);   // stalled reload
        drive_load(0, -1, 7);    // load_req while busy
        drive_load(0, 10, -1);   // abort after 10 bytes
        drive_load(0, -1, -1);   // full load after abort

        // Reset mid-load: 7 bytes give 4 coefficients, then reset
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        exp_q.push_back(12'h123); exp_q.push_back(12'h456);
        exp_q.push_back(12'h123); exp_q.push_back(12'h456);
        for (int i = 0; i < 7; i++) begin
            byte_in = pat[i % 3];
            byte_valid = 1'b1;
            @(negedge clk);
        end
        byte_valid = 1'b0;
        @(negedge clk);
        check("midload_queue_empty", exp_q.size(), 0);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            load_req = 1'($urandom_range(1, 0));
            byte_valid = 1'($urandom_range(1, 0));
            byte_in = 8'($urandom_range(255, 0));
            #1;
            check_all_zero("midload_reset_outputs");
            @(negedge clk);
        end
        load_req = 1'b0; byte_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("midload_after_release");
        $display("mid-load reset: outputs cleared, coef_ready=%0b", coef_ready);

        drive_load(0, -1, -1);   // recovery load

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
